// File: rtl/iomem_timer_pkg.sv
// Shared constants and helpers for the iomem interval timer.
// Register offsets, CTRL bit positions and byte-lane merge.
package iomem_timer_pkg;

    localparam int WIN_BYTES = 32;

    localparam logic [4:0] OFS_CTRL     = 5'h00;
    localparam logic [4:0] OFS_PRESCALE = 5'h04;
    localparam logic [4:0] OFS_RELOAD   = 5'h08;
    localparam logic [4:0] OFS_COUNT    = 5'h0C;
    localparam logic [4:0] OFS_STATUS   = 5'h10;
    localparam logic [4:0] OFS_SNAP_LO  = 5'h14;
    localparam logic [4:0] OFS_SNAP_HI  = 5'h18;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IRQ_EN = 2;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/iomem_timer_prescaler.sv
// Prescaler down-counter: ticks when it reaches 0, then reloads.
// Holds while disabled; clear forces it back to 0.
module iomem_timer_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] prescale,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? prescale : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/iomem_timer.sv
// Interval timer on the iomem bus with level irq.
// Optional 64-bit cycle snapshot: IOMEM_TIMER_SNAPSHOT_EN.
module iomem_timer
    import iomem_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    logic                  sel, req, wr, rd;
    logic [4:0]            ofs;
    logic                  en, auto_rl, irq_en, expired;
    logic [PRESCALE_W-1:0] prescale;
    logic [31:0]           reload, count;
    logic                  tick, expire;
    logic                  wr_ctrl, wr_pre, wr_rel, wr_cnt, clr_exp;
    logic [31:0]           rmux, pre_ext, pre_new, ctrl_new;

    assign sel = iomem_valid && (iomem_addr[31:5] == BASE_ADDR[31:5]);
    assign req = sel && !iomem_ready;
    assign wr  = req && (iomem_wstrb != 4'b0);
    assign rd  = req && (iomem_wstrb == 4'b0);
    assign ofs = {iomem_addr[4:2], 2'b00};

    assign wr_ctrl = wr && (ofs == OFS_CTRL);
    assign wr_pre  = wr && (ofs == OFS_PRESCALE);
    assign wr_rel  = wr && (ofs == OFS_RELOAD);
    assign wr_cnt  = wr && (ofs == OFS_COUNT);
    assign clr_exp = wr && (ofs == OFS_STATUS) && iomem_wstrb[0] && iomem_wdata[0];

    assign expire = tick && (count == 32'd0);

    always_comb begin
        pre_ext = '0;
        pre_ext[PRESCALE_W-1:0] = prescale;
    end

    assign pre_new  = merge_bytes(pre_ext, iomem_wdata, iomem_wstrb);
    assign ctrl_new = merge_bytes({29'd0, irq_en, auto_rl, en},
                                  iomem_wdata, iomem_wstrb);

    iomem_timer_prescaler #(
        .W(PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clear    (wr_cnt),
        .prescale (prescale),
        .tick     (tick)
    );

`ifdef IOMEM_TIMER_SNAPSHOT_EN
    logic [63:0] cycles;
    logic [31:0] shadow;

    // Reading the low word freezes the high word for a torn-free pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles <= '0;
            shadow <= '0;
        end else begin
            cycles <= cycles + 64'd1;
            if (rd && ofs == OFS_SNAP_LO) shadow <= cycles[63:32];
        end
    end
`endif

    always_comb begin
        rmux = '0;
        case (ofs)
            OFS_CTRL: begin
                rmux[CTRL_EN]     = en;
                rmux[CTRL_AUTO]   = auto_rl;
                rmux[CTRL_IRQ_EN] = irq_en;
            end
            OFS_PRESCALE: rmux[PRESCALE_W-1:0] = prescale;
            OFS_RELOAD:   rmux = reload;
            OFS_COUNT:    rmux = count;
            OFS_STATUS:   rmux[0] = expired;
`ifdef IOMEM_TIMER_SNAPSHOT_EN
            OFS_SNAP_LO:  rmux = cycles[31:0];
            OFS_SNAP_HI:  rmux = shadow;
`endif
            default:      rmux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            irq         <= 1'b0;
            en          <= 1'b0;
            auto_rl     <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= '0;
            reload      <= '0;
            count       <= '0;
            expired     <= 1'b0;
        end else begin
            iomem_ready <= req;
            iomem_rdata <= rd ? rmux : 32'd0;
            irq         <= expired && irq_en;

            // A CTRL write overrides the one-shot self-disable.
            if (wr_ctrl) begin
                en      <= ctrl_new[CTRL_EN];
                auto_rl <= ctrl_new[CTRL_AUTO];
                irq_en  <= ctrl_new[CTRL_IRQ_EN];
            end else if (expire && !auto_rl) begin
                en <= 1'b0;
            end

            if (wr_pre) prescale <= pre_new[PRESCALE_W-1:0];
            if (wr_rel) reload <= merge_bytes(reload, iomem_wdata, iomem_wstrb);

            if (wr_cnt) begin
                count <= merge_bytes(count, iomem_wdata, iomem_wstrb);
            end else if (tick) begin
                if (count != 32'd0) count <= count - 32'd1;
                else if (auto_rl)   count <= reload;
            end

            if (expire)       expired <= 1'b1;
            else if (clr_exp) expired <= 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{iomem_addr[1:0], pre_new, ctrl_new};

endmodule
